fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch FSM between a PLL-clocked core and instruction memory
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   lock                  : PLL locked; fetch idles while low
//   imem_req/imem_addr    : one-cycle read request and its address
//   imem_valid/imem_rdata : read response strobe and data
//   out_valid/out_ready   : fetched-instruction handshake to the datapath
//   out_inst/out_pc       : fetched word and its address
//   redirect/redirect_pc  : taken branch/jump and its target
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, out_pc_n, target;
  logic [DATA_W-1:0] out_inst_n;
  logic discard, discard_n;
  assign target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_req = state == REQ;
  assign imem_addr = imem_req ? pc : '0;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      out_inst <= '0;
      out_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      discard <= discard_n;
      out_inst <= out_inst_n;
      out_pc <= out_pc_n;
    end
  end
  // discard marks an in-flight response made stale by a redirect
  always_comb begin
    state_n = state;
    pc_n = pc;
    discard_n = discard;
    out_inst_n = out_inst;
    out_pc_n = out_pc;
    if (!lock) begin
      state_n = IDLE;
      pc_n = RESET_PC;
      discard_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          state_n = WAIT;
          pc_n = redirect ? target : pc;
          discard_n = redirect;
        end
        WAIT: begin
          if (redirect) begin
            pc_n = target;
            state_n = imem_valid ? REQ : WAIT;
            discard_n = !imem_valid;
          end else if (imem_valid && discard) begin
            discard_n = 1'b0;
            state_n = REQ;
          end else if (imem_valid) begin
            out_inst_n = imem_rdata;
            out_pc_n = pc;
            pc_n = pc + ADDR_W'(4);
            state_n = HOLD;
          end
        end
        HOLD: begin
          pc_n = redirect ? target : pc;
          state_n = (redirect || out_ready) ? REQ : HOLD;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage with a latency-programmable memory model
module tb_fetch_stage;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} out_t;
  logic clk = 1'b0;
  logic reset, lock, imem_req, imem_valid, out_valid, out_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, out_inst, out_pc, redirect_pc;
  int errors = 0, checks = 0, lat = 1, mcnt = 0, hs_n = 0, cyc = 0;
  logic [31:0] maddr = '0;
  int hs_cyc[$];
  logic [31:0] exp_addr[$];
  out_t exp_out[$];
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .reset(reset), .lock(lock),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk(tag, out_valid, 1);
  endtask
  initial begin : env
    out_t e;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        chk("addr_q", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) chk("imem_addr", imem_addr, exp_addr.pop_front());
        maddr = imem_addr;
        mcnt = lat;
      end
      if (out_valid && out_ready) begin
        hs_n++;
        hs_cyc.push_back(cyc);
        chk("out_q", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) begin
          e = exp_out.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_valid = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem(maddr);
        end
      end
    end
  end
  initial begin : stim
    bit done = 0;
    reset = 1'b1; lock = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    lock = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("prio_req", imem_req, 0);
    chk("prio_valid", out_valid, 0);
    foreach (exp_addr[i]) exp_addr.delete(i);
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    exp_out.push_back({32'h0, mem(32'h0)}); exp_out.push_back({32'h4, mem(32'h4)});
    exp_out.push_back({32'h8, mem(32'h8)}); exp_out.push_back({32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    reset = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 60 && hs_n < 4; i++) begin
      tick();
      redirect = 1'b0;
      if (!done && out_valid && out_pc == 32'h8) begin
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        done = 1;
      end
    end
    out_ready = 1'b0;
    chk("p1_hs", hs_n, 4);
    chk("p1_redir", done, 1);
    chk("p1_hs_len", hs_cyc.size() >= 3, 1);
    if (hs_cyc.size() >= 3) begin
      chk("gap_0_4", hs_cyc[1] - hs_cyc[0], 3);
      chk("gap_4_8", hs_cyc[2] - hs_cyc[1], 3);
    end
    wait_valid("v_wrap");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 32'h0);
      chk("hold_inst", out_inst, mem(32'h0));
      chk("hold_noreq", imem_req, 0);
      tick();
    end
    exp_out.push_back({32'h0, mem(32'h0)});
    exp_addr.push_back(32'h4); exp_addr.push_back(32'h100);
    out_ready = 1'b1; lat = 3;
    tick();
    out_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    wait_valid("v_redir");
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_inst", out_inst, mem(32'h100));
    exp_out.push_back({32'h100, mem(32'h100)});
    exp_addr.push_back(32'h104);
    out_ready = 1'b1; lat = 2;
    tick();
    out_ready = 1'b0;
    tick();
    lock = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("unlock_valid", out_valid, 0);
      chk("unlock_req", imem_req, 0);
      redirect = i == 0;
      redirect_pc = 32'h200;
      tick();
    end
    redirect = 1'b0;
    exp_addr.push_back(32'h0);
    lock = 1'b1; lat = 1;
    wait_valid("v_relock");
    chk("relock_pc", out_pc, 32'h0);
    chk("relock_inst", out_inst, mem(32'h0));
    exp_out.push_back({32'h0, mem(32'h0)});
    exp_addr.push_back(32'h4); exp_addr.push_back(32'h0);
    out_ready = 1'b1; lat = 3;
    tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_inst", out_inst, 0);
    wait_valid("v_rst");
    chk("rst_fetch_pc", out_pc, 32'h0);
    chk("rst_fetch_inst", out_inst, mem(32'h0));
    exp_out.push_back({32'h0, mem(32'h0)});
    exp_addr.push_back(32'h4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; lock = 1'b0;
    tick(); tick(); tick();
    chk("end_addr_q", exp_addr.size(), 0);
    chk("end_out_q", exp_out.size(), 0);
    chk("end_hs", hs_n, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
